// File: rtl/mem_pkg.sv
// Shared op encodings and op-class helpers for the M-stage memory access path.
package mem_pkg;

  // Memory op codes carried in the EX/MEM pipeline register.
  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  localparam int unsigned OP_W = 4;

  // True for any op that reads the DM into the register file.
  function automatic logic is_load(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  // True for any op that writes the DM.
  function automatic logic is_store(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_SW, OP_SH, OP_SB: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational alignment unit: access-fault detection, sub-word store
// merge into the DM read word, and load byte/halfword extraction.
module mem_align
  import mem_pkg::*;
#(
  parameter int DM_BYTES = 4096
) (
  input  logic            valid_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  input  logic [31:0]     dout_i,
  output logic            load_o,
  output logic            store_o,
  output logic            fault_o,
  output logic [31:0]     din_o,
  output logic [31:0]     rdata_o
);

  localparam logic [31:0] DM_LIMIT = 32'(DM_BYTES);

  logic           misaligned;
  logic           out_of_range;
  logic [3:0]     lane_we;
  logic [3:0][7:0] lane_src;
  logic [31:0]    byte_shift;
  logic [31:0]    half_shift;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;

  // Classify the op and decide whether the access must be trapped.
  always_comb begin
    load_o       = is_load(op_i);
    store_o      = is_store(op_i);
    misaligned   = 1'b0;
    case (op_i)
      OP_LW, OP_SW:         misaligned = (addr_i[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr_i[0];
      default:              misaligned = 1'b0;
    endcase
    out_of_range = (addr_i >= DM_LIMIT);
    fault_o      = valid_i & (load_o | store_o) & (misaligned | out_of_range);
  end

  // Per byte lane: pick the store source byte or keep the DM read byte, so
  // SB/SH become a single-cycle read-modify-write on the combinational read.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_we[gi]  = (op_i == OP_SW)
                        | ((op_i == OP_SH) & (addr_i[1] == LANE[1]))
                        | ((op_i == OP_SB) & (addr_i[1:0] == LANE));
    assign lane_src[gi] = (op_i == OP_SB) ? wdata_i[7:0] :
                          (op_i == OP_SH) ? wdata_i[8*(gi%2) +: 8] :
                                            wdata_i[8*gi +: 8];
    assign din_o[8*gi +: 8] = lane_we[gi] ? lane_src[gi] : dout_i[8*gi +: 8];
  end

  // Little-endian extraction of the addressed byte/halfword, then extension.
  always_comb begin
    byte_shift = dout_i >> {addr_i[1:0], 3'b000};
    half_shift = dout_i >> {addr_i[1], 4'b0000};
    ld_byte    = byte_shift[7:0];
    ld_half    = half_shift[15:0];
    rdata_o    = dout_i;
    case (op_i)
      OP_LB:   rdata_o = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  rdata_o = {24'h000000, ld_byte};
      OP_LH:   rdata_o = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  rdata_o = {16'h0000, ld_half};
      default: rdata_o = dout_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store front end: drives the word-wide DM, registers load
// results into the MEM/WB stage and keeps sticky access-fault status.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DM_BYTES = 4096,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_valid,
  input  logic [3:0]       m_op,
  input  logic [31:0]      m_pc,
  input  logic [31:0]      m_addr,
  input  logic [31:0]      m_wdata,
  input  logic [4:0]       m_rd,
  input  logic             hold,
  input  logic             flush,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_we,
  input  logic [31:0]      dm_dout,
  output logic             w_valid,
  output logic [31:0]      w_pc,
  output logic [4:0]       w_rd,
  output logic             w_regwrite,
  output logic [31:0]      w_rdata,
  output logic             exc_flag,
  output logic [31:0]      exc_pc,
  output logic [CNT_W-1:0] exc_cnt
);

  logic        op_load;
  logic        op_store;
  logic        fault;
  logic [31:0] ext_rdata;

  logic             w_valid_q,    w_valid_d;
  logic [31:0]      w_pc_q,       w_pc_d;
  logic [4:0]       w_rd_q,       w_rd_d;
  logic             w_regwrite_q, w_regwrite_d;
  logic [31:0]      w_rdata_q,    w_rdata_d;
  logic             exc_flag_q,   exc_flag_d;
  logic [31:0]      exc_pc_q,     exc_pc_d;
  logic [CNT_W-1:0] exc_cnt_q,    exc_cnt_d;

  mem_align #(
    .DM_BYTES (DM_BYTES)
  ) u_align (
    .valid_i (m_valid),
    .op_i    (m_op),
    .addr_i  (m_addr),
    .wdata_i (m_wdata),
    .dout_i  (dm_dout),
    .load_o  (op_load),
    .store_o (op_store),
    .fault_o (fault),
    .din_o   (dm_din),
    .rdata_o (ext_rdata)
  );

  // DM side: word address always; write only for a clean, non-held store.
  assign dm_addr = {m_addr[31:2], 2'b00};
  assign dm_we   = m_valid & op_store & ~fault & ~hold & ~reset;

  // W-stage next state: flush kills, hold freezes, otherwise capture the op;
  // faults are recorded only on a real capture so a held op counts once.
  always_comb begin
    w_valid_d    = w_valid_q;
    w_pc_d       = w_pc_q;
    w_rd_d       = w_rd_q;
    w_regwrite_d = w_regwrite_q;
    w_rdata_d    = w_rdata_q;
    exc_flag_d   = exc_flag_q;
    exc_pc_d     = exc_pc_q;
    exc_cnt_d    = exc_cnt_q;
    if (flush) begin
      w_valid_d    = 1'b0;
      w_regwrite_d = 1'b0;
    end else if (!hold) begin
      w_valid_d    = m_valid;
      w_pc_d       = m_pc;
      w_rd_d       = m_rd;
      w_rdata_d    = ext_rdata;
      w_regwrite_d = m_valid & op_load & ~fault & (m_rd != 5'd0);
      if (fault) begin
        exc_flag_d = 1'b1;
        if (!exc_flag_q) begin
          exc_pc_d = m_pc;
        end
        if (exc_cnt_q != {CNT_W{1'b1}}) begin
          exc_cnt_d = exc_cnt_q + 1'b1;
        end
      end
    end
  end

  // W-stage and fault-status registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid_q    <= 1'b0;
      w_pc_q       <= '0;
      w_rd_q       <= '0;
      w_regwrite_q <= 1'b0;
      w_rdata_q    <= '0;
      exc_flag_q   <= 1'b0;
      exc_pc_q     <= '0;
      exc_cnt_q    <= '0;
    end else begin
      w_valid_q    <= w_valid_d;
      w_pc_q       <= w_pc_d;
      w_rd_q       <= w_rd_d;
      w_regwrite_q <= w_regwrite_d;
      w_rdata_q    <= w_rdata_d;
      exc_flag_q   <= exc_flag_d;
      exc_pc_q     <= exc_pc_d;
      exc_cnt_q    <= exc_cnt_d;
    end
  end

  assign w_valid    = w_valid_q;
  assign w_pc       = w_pc_q;
  assign w_rd       = w_rd_q;
  assign w_regwrite = w_regwrite_q;
  assign w_rdata    = w_rdata_q;
  assign exc_flag   = exc_flag_q;
  assign exc_pc     = exc_pc_q;
  assign exc_cnt    = exc_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory model plus W/fault model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset, m_valid, hold, flush;
  logic [3:0]  m_op;
  logic [31:0] m_pc, m_addr, m_wdata;
  logic [4:0]  m_rd;
  logic [31:0] dm_addr, dm_din, dm_dout;
  logic        dm_we;
  logic        w_valid, w_regwrite, exc_flag;
  logic [31:0] w_pc, w_rdata, exc_pc;
  logic [4:0]  w_rd;
  logic [7:0]  exc_cnt;

  always #5 clk = ~clk;

  mem_access_unit #(.DM_BYTES(4096), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_op(m_op), .m_pc(m_pc),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .hold(hold), .flush(flush),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout),
    .w_valid(w_valid), .w_pc(w_pc), .w_rd(w_rd), .w_regwrite(w_regwrite),
    .w_rdata(w_rdata), .exc_flag(exc_flag), .exc_pc(exc_pc), .exc_cnt(exc_cnt)
  );

  // Data memory driven by the DUT: combinational read, posedge write.
  logic [31:0] dm_mem [1024];
  assign dm_dout = dm_mem[dm_addr[11:2]];
  always @(posedge clk) if (dm_we) dm_mem[dm_addr[11:2]] <= dm_din;

  // Reference model: byte-addressed memory and expected W/fault state.
  logic [7:0]  ref_mem [4096];
  logic        e_v, e_rw, e_rknown, e_flag;
  logic [31:0] e_pc, e_rdata, e_epc;
  logic [4:0]  e_rd;
  logic [7:0]  e_cnt;
  logic        e_we, e_fault;
  logic [31:0] e_din;
  logic        s_we;
  logic [31:0] s_din, s_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Drive one op for one cycle, sample DM-side outputs mid-cycle, advance the
  // model at the edge; W outputs are valid on return.
  task automatic apply_op(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic v, input logic h, input logic f, input logic r);
    logic ld, st, mis, oor;
    logic [7:0] b [4];
    logic [31:0] lval;
    int base, a;
    @(negedge clk);
    m_op = op; m_pc = pc; m_addr = addr; m_wdata = wd; m_rd = rd;
    m_valid = v; hold = h; flush = f; reset = r;
    #1;
    s_we = dm_we; s_din = dm_din; s_addr = dm_addr;
    ld  = (op >= 4'd1 && op <= 4'd5);
    st  = (op >= 4'd6 && op <= 4'd8);
    mis = ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00) ||
          ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0]);
    oor = (addr >= 32'd4096);
    e_fault = v && (ld || st) && (mis || oor);
    e_we    = v && st && !e_fault && !h && !r;
    base = int'(addr[11:2]) * 4;
    a    = int'(addr[11:0]);
    for (int k = 0; k < 4; k++) b[k] = ref_mem[base + k];
    if (op == OP_SW) for (int k = 0; k < 4; k++) b[k] = wd[8*k +: 8];
    if (op == OP_SH) begin
      b[2*int'(addr[1])]     = wd[7:0];
      b[2*int'(addr[1]) + 1] = wd[15:8];
    end
    if (op == OP_SB) b[int'(addr[1:0])] = wd[7:0];
    e_din = {b[3], b[2], b[1], b[0]};
    lval = 32'h0;
    if (!oor) begin
      case (op)
        OP_LW:  lval = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        OP_LB:  lval = {{24{ref_mem[a][7]}}, ref_mem[a]};
        OP_LBU: lval = {24'h0, ref_mem[a]};
        OP_LH:  lval = {{16{ref_mem[a+1][7]}}, ref_mem[a+1], ref_mem[a]};
        OP_LHU: lval = {16'h0, ref_mem[a+1], ref_mem[a]};
        default: lval = 32'h0;
      endcase
    end
    $display("t=%0t op=%0d pc=%h addr=%h wd=%h rd=%0d v=%0b h=%0b f=%0b r=%0b we=%0b din=%h",
             $time, op, pc, addr, wd, rd, v, h, f, r, s_we, s_din);
    @(posedge clk);
    if (r) begin
      e_v = 0; e_rw = 0; e_pc = 0; e_rd = 0; e_rdata = 0; e_rknown = 1;
      e_flag = 0; e_epc = 0; e_cnt = 0;
    end else if (f) begin
      e_v = 0; e_rw = 0;
    end else if (!h) begin
      e_v = v; e_pc = pc; e_rd = rd;
      e_rw = v && ld && !e_fault && (rd != 0);
      e_rknown = v && ld && !e_fault;
      e_rdata = lval;
      if (e_fault) begin
        if (!e_flag) e_epc = pc;
        e_flag = 1;
        if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
      end
    end
    if (e_we) for (int k = 0; k < 4; k++) ref_mem[base + k] = e_din[8*k +: 8];
    #1;
  endtask

  task automatic test_reset();
    apply_op(OP_SW, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd1, 1, 0, 0, 1);
    n_checks++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", s_we); end
    n_checks++; if ({w_valid, w_regwrite, exc_flag} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {w_valid, w_regwrite, exc_flag}); end
    n_checks++; if ({w_pc, w_rdata, exc_pc} !== 96'h0) begin n_fail++; $display("FAIL reset_words got=%h exp=0", {w_pc, w_rdata, exc_pc}); end
    n_checks++; if ({w_rd, exc_cnt} !== 13'h0) begin n_fail++; $display("FAIL reset_rd_cnt got=%h exp=0", {w_rd, exc_cnt}); end
  endtask

  task automatic test_word_store_load();
    apply_op(OP_SW, 32'h100, 32'h10, 32'h12345678, 5'd0, 1, 0, 0, 0);
    n_checks++; if (s_we !== 1'b1) begin n_fail++; $display("FAIL sw_we got=%b exp=1", s_we); end
    n_checks++; if (s_din !== 32'h12345678) begin n_fail++; $display("FAIL sw_din got=%h exp=12345678", s_din); end
    n_checks++; if (s_addr !== 32'h10) begin n_fail++; $display("FAIL sw_addr got=%h exp=00000010", s_addr); end
    apply_op(OP_LW, 32'h104, 32'h10, 32'h0, 5'd5, 1, 0, 0, 0);
    n_checks++; if (w_rdata !== 32'h12345678) begin n_fail++; $display("FAIL lw_rdata got=%h exp=12345678", w_rdata); end
    n_checks++; if ({w_valid, w_regwrite, w_rd} !== {2'b11, 5'd5}) begin n_fail++; $display("FAIL lw_w got=%b/%b/%0d exp=1/1/5", w_valid, w_regwrite, w_rd); end
    n_checks++; if (w_pc !== 32'h104) begin n_fail++; $display("FAIL lw_pc got=%h exp=00000104", w_pc); end
  endtask

  task automatic test_sub_word();
    apply_op(OP_SB, 32'h108, 32'h11, 32'h000000AB, 5'd0, 1, 0, 0, 0);
    n_checks++; if (s_din !== 32'h1234AB78 || s_we !== 1'b1) begin n_fail++; $display("FAIL sb_din got=%h we=%b exp=1234AB78 we=1", s_din, s_we); end
    n_checks++; if (s_addr !== 32'h10) begin n_fail++; $display("FAIL sb_addr got=%h exp=00000010", s_addr); end
    apply_op(OP_LB, 32'h10C, 32'h11, 32'h0, 5'd6, 1, 0, 0, 0);
    n_checks++; if (w_rdata !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL lb_rdata got=%h exp=FFFFFFAB", w_rdata); end
    apply_op(OP_LBU, 32'h110, 32'h11, 32'h0, 5'd6, 1, 0, 0, 0);
    n_checks++; if (w_rdata !== 32'h000000AB) begin n_fail++; $display("FAIL lbu_rdata got=%h exp=000000AB", w_rdata); end
    apply_op(OP_SH, 32'h114, 32'h12, 32'h00008001, 5'd0, 1, 0, 0, 0);
    n_checks++; if (s_din !== 32'h8001AB78 || s_we !== 1'b1) begin n_fail++; $display("FAIL sh_din got=%h we=%b exp=8001AB78 we=1", s_din, s_we); end
    apply_op(OP_LH, 32'h118, 32'h12, 32'h0, 5'd7, 1, 0, 0, 0);
    n_checks++; if (w_rdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_rdata got=%h exp=FFFF8001", w_rdata); end
    apply_op(OP_LHU, 32'h11C, 32'h12, 32'h0, 5'd7, 1, 0, 0, 0);
    n_checks++; if (w_rdata !== 32'h00008001) begin n_fail++; $display("FAIL lhu_rdata got=%h exp=00008001", w_rdata); end
  endtask

  task automatic test_faults();
    apply_op(OP_SW, 32'h3004, 32'h13, 32'hCAFEF00D, 5'd0, 1, 0, 0, 0);
    n_checks++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL misalign_sw_we got=%b exp=0", s_we); end
    apply_op(OP_LW, 32'h3008, 32'h1000, 32'h0, 5'd7, 1, 0, 0, 0);
    n_checks++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL oor_lw_we got=%b exp=0", s_we); end
    n_checks++; if (exc_flag !== 1'b1 || exc_pc !== 32'h3004) begin n_fail++; $display("FAIL exc_status got=%b/%h exp=1/00003004", exc_flag, exc_pc); end
    n_checks++; if (exc_cnt !== 8'd2) begin n_fail++; $display("FAIL exc_cnt got=%0d exp=2", exc_cnt); end
    n_checks++; if (w_regwrite !== 1'b0 || w_valid !== 1'b1) begin n_fail++; $display("FAIL fault_w got=rw%b/v%b exp=rw0/v1", w_regwrite, w_valid); end
  endtask

  task automatic test_hold();
    logic [31:0] pc0, rd0;
    logic        v0;
    logic [7:0]  c0;
    pc0 = w_pc; rd0 = w_rdata; v0 = w_valid; c0 = exc_cnt;
    for (int i = 0; i < 3; i++) begin
      apply_op(OP_SH, 32'h4000, 32'h11, 32'h00001234, 5'd9, 1, 1, 0, 0);
      n_checks++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL hold_we[%0d] got=%b exp=0", i, s_we); end
      n_checks++; if (w_pc !== pc0 || w_rdata !== rd0 || w_valid !== v0) begin n_fail++; $display("FAIL hold_w[%0d] got=%h/%h/%b exp=%h/%h/%b", i, w_pc, w_rdata, w_valid, pc0, rd0, v0); end
      n_checks++; if (exc_cnt !== c0) begin n_fail++; $display("FAIL hold_cnt[%0d] got=%0d exp=%0d", i, exc_cnt, c0); end
    end
    apply_op(OP_SH, 32'h4000, 32'h11, 32'h00001234, 5'd9, 1, 0, 0, 0);
    n_checks++; if (exc_cnt !== c0 + 8'd1) begin n_fail++; $display("FAIL hold_release_cnt got=%0d exp=%0d", exc_cnt, c0 + 8'd1); end
    n_checks++; if (w_pc !== 32'h4000 || exc_pc !== 32'h3004) begin n_fail++; $display("FAIL hold_release_pc got=%h/%h exp=00004000/00003004", w_pc, exc_pc); end
    apply_op(OP_SW, 32'h4004, 32'h20, 32'h55555555, 5'd0, 1, 1, 0, 0);
    n_checks++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL hold_sw_we got=%b exp=0", s_we); end
  endtask

  task automatic test_rd0_flush();
    logic [7:0] c0;
    apply_op(OP_LW, 32'h5000, 32'h10, 32'h0, 5'd0, 1, 0, 0, 0);
    n_checks++; if (w_valid !== 1'b1 || w_regwrite !== 1'b0) begin n_fail++; $display("FAIL rd0 got=v%b/rw%b exp=v1/rw0", w_valid, w_regwrite); end
    apply_op(OP_LW, 32'h5004, 32'h10, 32'h0, 5'd3, 1, 0, 1, 0);
    n_checks++; if (w_valid !== 1'b0 || w_regwrite !== 1'b0) begin n_fail++; $display("FAIL flush_lw got=v%b/rw%b exp=v0/rw0", w_valid, w_regwrite); end
    c0 = exc_cnt;
    apply_op(OP_SW, 32'h5008, 32'h13, 32'h0, 5'd0, 1, 0, 1, 0);
    n_checks++; if (s_we !== 1'b0 || exc_cnt !== c0) begin n_fail++; $display("FAIL flush_fault got=we%b/cnt%0d exp=we0/cnt%0d", s_we, exc_cnt, c0); end
  endtask

  task automatic test_reset_mid();
    apply_op(OP_SW, 32'h6000, 32'h20, 32'hDEADBEEF, 5'd0, 1, 0, 0, 1);
    n_checks++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL rst_sw_we got=%b exp=0", s_we); end
    n_checks++; if ({w_valid, w_regwrite, exc_flag, w_pc, w_rd, w_rdata, exc_pc, exc_cnt} !== '0) begin n_fail++; $display("FAIL rst_clear got=%b%b%b pc=%h rdata=%h epc=%h cnt=%0d exp=all 0", w_valid, w_regwrite, exc_flag, w_pc, w_rdata, exc_pc, exc_cnt); end
    apply_op(OP_LW, 32'h6004, 32'h20, 32'h0, 5'd1, 1, 0, 0, 0);
    n_checks++; if (w_rdata !== e_rdata) begin n_fail++; $display("FAIL rst_no_write got=%h exp=%h", w_rdata, e_rdata); end
  endtask

  task automatic test_saturation();
    apply_op(OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1);
    for (int i = 0; i < 260; i++)
      apply_op(OP_LH, 32'h7000 + 32'(i * 4), 32'h1002, 32'h0, 5'd2, 1, 0, 0, 0);
    n_checks++; if (exc_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_cnt got=%0d exp=255", exc_cnt); end
    n_checks++; if (exc_pc !== 32'h7000 || exc_flag !== 1'b1) begin n_fail++; $display("FAIL sat_pc got=%h/%b exp=00007000/1", exc_pc, exc_flag); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    apply_op(OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) addr = 32'h1000 + $urandom_range(0, 255);
      else addr = 32'($urandom_range(0, 63));
      apply_op(4'($urandom_range(0, 8)), $urandom, addr, $urandom, 5'($urandom_range(0, 31)),
               ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 11) == 0), ($urandom_range(0, 96) == 0));
      n_checks++; if (s_we !== e_we) begin n_fail++; $display("FAIL rnd_we[%0d] got=%b exp=%b", i, s_we, e_we); end
      n_checks++; if (s_addr !== {m_addr[31:2], 2'b00}) begin n_fail++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, s_addr, {m_addr[31:2], 2'b00}); end
      if (e_we) begin
        n_checks++; if (s_din !== e_din) begin n_fail++; $display("FAIL rnd_din[%0d] got=%h exp=%h", i, s_din, e_din); end
      end
      n_checks++; if ({w_valid, w_regwrite, w_rd, w_pc} !== {e_v, e_rw, e_rd, e_pc}) begin n_fail++; $display("FAIL rnd_w[%0d] got=%b/%b/%0d/%h exp=%b/%b/%0d/%h", i, w_valid, w_regwrite, w_rd, w_pc, e_v, e_rw, e_rd, e_pc); end
      if (e_rknown) begin
        n_checks++; if (w_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", i, w_rdata, e_rdata); end
      end
      n_checks++; if ({exc_flag, exc_pc, exc_cnt} !== {e_flag, e_epc, e_cnt}) begin n_fail++; $display("FAIL rnd_exc[%0d] got=%b/%h/%0d exp=%b/%h/%0d", i, exc_flag, exc_pc, exc_cnt, e_flag, e_epc, e_cnt); end
    end
  endtask

  initial begin
    reset = 1; m_valid = 0; hold = 0; flush = 0; m_op = OP_NONE;
    m_pc = 0; m_addr = 0; m_wdata = 0; m_rd = 0;
    for (int i = 0; i < 1024; i++) dm_mem[i] = 32'h0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
    e_v = 0; e_rw = 0; e_rknown = 0; e_flag = 0; e_pc = 0; e_rdata = 0;
    e_epc = 0; e_rd = 0; e_cnt = 0;
    test_reset();
    test_word_store_load();
    test_sub_word();
    test_faults();
    test_hold();
    test_rd0_flush();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name:
mem_access_unit

Overview:
M-stage load/store front end that sits directly upstream of the word-wide data memory (DM), which has a combinational read and a posedge write. Each cycle it takes one memory op from the EX/MEM pipeline register. It drives the DM word address, write data and write enable. For SB/SH it performs a same-cycle read-modify-write merge. It extracts and extends load data and registers the result into the MEM/WB stage. Misaligned and out-of-range accesses are trapped with a sticky status.

Parameters:
DM_BYTES, 4096, DM capacity in bytes (1024 words); any address >= DM_BYTES is out of range.
CNT_W, 8, width of the saturating exception counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_valid  in  1  M-stage op valid
m_op  in  4  op code, defined in mem_pkg: NONE, LW, LH, LHU, LB, LBU, SW, SH, SB
m_pc  in  32  PC of the M-stage instruction
m_addr  in  32  byte address (ALU result)
m_wdata  in  32  store source register value
m_rd  in  5  load destination register
hold  in  1  W stage stalled; M op will be re-presented
flush  in  1  kill the op entering W
dm_addr  out  32  word-aligned address to DM, equal to {m_addr[31:2],2'b00}
dm_din  out  32  merged word to DM
dm_we  out  1  DM write enable
dm_dout  in  32  DM combinational read word
w_valid  out  1  W-stage valid
w_pc  out  32  W-stage PC
w_rd  out  5  W-stage destination register
w_regwrite  out  1  load result must be written to the register file
w_rdata  out  32  extended load data
exc_flag  out  1  sticky: an access fault occurred
exc_pc  out  32  PC of the first faulting access
exc_cnt  out  CNT_W  number of faults, saturating

Behaviour:
- Byte order is little-endian: byte k = dm_dout[8k+7:8k], with k = m_addr[1:0].
- Fault (combinational) when m_valid and a load/store op and any of:
  - LW/SW with m_addr[1:0] != 0;
  - LH/LHU/SH with m_addr[0] != 0;
  - m_addr >= DM_BYTES.
- dm_we = m_valid & store & ~fault & ~hold & ~reset. It is never asserted for NONE or for loads.
- dm_din:
  - SW: m_wdata.
  - SH: dm_dout with halfword m_addr[1] replaced by m_wdata[15:0].
  - SB: dm_dout with byte k replaced by m_wdata[7:0].
  - Otherwise: dm_dout (don't-care).
- The RMW completes in one cycle because the DM read is combinational. The DM commits at the same posedge. A load in the next cycle sees the new data, so no forwarding is needed.
- Load extraction: LB/LBU sign/zero-extend byte k. LH/LHU sign/zero-extend halfword m_addr[1]. LW passes the whole word.
- W register, updated at posedge clk, priority reset > flush > hold > load:
  - reset: w_valid, w_regwrite, w_pc, w_rd, w_rdata, exc_flag, exc_pc, exc_cnt all 0.
  - flush: w_valid=0, w_regwrite=0; other W fields are don't-care, held at their old values.
  - hold: all W fields unchanged.
  - else: w_valid=m_valid; w_pc=m_pc; w_rd=m_rd; w_rdata=extracted data; w_regwrite = m_valid & load & ~fault & (m_rd != 0).
- Fault bookkeeping happens on the non-hold, non-flush capture edge only, so a held op is counted once:
  - exc_flag is set to 1 and stays set until reset;
  - exc_pc is captured only when exc_flag was 0;
  - exc_cnt increments and saturates at all-ones.
- Flush in the same cycle as a fault: the fault is not recorded; a DM write is still suppressed by the fault.
- Reset asserted mid-stream: dm_we=0 in that cycle, and W state clears at the edge.
- Latency: store takes 1 cycle to DM. Load data is visible on w_rdata 1 cycle after the op is presented.

Decomposition:
- mem_pkg holds the m_op encodings (NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8) and the is_load/is_store helper functions.
- One natural sub-module, mem_align: purely combinational fault detection, store merge and load extraction.
- The top level holds the W register and the fault bookkeeping.

Test Plan:
- SW 0x12345678 @0x10, then LW @0x10: dm_we=1, dm_din=0x12345678; next op gives w_rdata=0x12345678, w_regwrite=1.
- With word @0x10 = 0x12345678, SB 0xAB @0x11 -> dm_din=0x1234AB78. Then LB @0x11 -> w_rdata=0xFFFFFFAB; LBU @0x11 -> w_rdata=0x000000AB.
- SH 0x8001 @0x12 on word 0x1234AB78 -> dm_din=0x8001AB78. Then LH @0x12 -> 0xFFFF8001; LHU @0x12 -> 0x00008001.
- SW @0x13 with pc=0x3004, then LW @0x1000 with pc=0x3008 -> dm_we=0 both times; exc_flag=1, exc_pc=0x3004, exc_cnt=2, w_regwrite=0.
- hold=1 for 3 cycles during a faulting SH -> dm_we=0 throughout; W fields unchanged; exc_cnt increments exactly once, after hold drops.
- LW to rd=0 -> w_regwrite=0. flush during LW @0x10 -> w_valid=0. reset during SW -> dm_we=0, and all outputs read 0 on the next cycle.
